// File: rtl/vga_rect_writer.sv
// rtl/vga_rect_writer.sv - filled-rectangle write engine for the VGA framebuffer
//
// Accepts one axis-aligned rectangle per valid/ready handshake, clips it to the
// screen and writes one dot per clock in raster order. The address layout is
// y*XMAX + x, which is the layout the scan-out side reads.
//
// Optional feature macro: VGA_RECT_WRITER_CLEAR_EN (adds clear port + CLEAR state)
//
// Ports:
//   vga_clock   in   1   sole clock
//   resetn      in   1   asynchronous active-low reset
//   cmd_valid   in   1   command offered
//   cmd_ready   out  1   engine idle and accepting
//   cmd_x       in   XW  left column
//   cmd_y       in   YW  top row
//   cmd_w       in   XW  width in dots
//   cmd_h       in   YW  height in dots
//   cmd_colour  in   CW  fill colour
//   mem_address out  AW  write address
//   mem_data    out  CW  write data
//   mem_wren    out  1   write enable
//   busy        out  1   command in progress
//   done        out  1   one-cycle completion pulse
//   clear       in   1   full-screen clear request (VGA_RECT_WRITER_CLEAR_EN only)
module vga_rect_writer #(
    parameter string RESOLUTION              = "320x240",
    parameter int    BITS_PER_COLOUR_CHANNEL = 1,
    parameter string MONOCHROME              = "FALSE",
    localparam bit   LORES = (RESOLUTION == "160x120"),
    localparam int   XW    = LORES ? 8 : 9,
    localparam int   YW    = LORES ? 7 : 8,
    localparam int   AW    = LORES ? 15 : 17,
    localparam int   CW    = (MONOCHROME == "TRUE") ? 1 : 3 * BITS_PER_COLOUR_CHANNEL
) (
    input  logic          vga_clock,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x,
    input  logic [YW-1:0] cmd_y,
    input  logic [XW-1:0] cmd_w,
    input  logic [YW-1:0] cmd_h,
    input  logic [CW-1:0] cmd_colour,
    output logic [AW-1:0] mem_address,
    output logic [CW-1:0] mem_data,
    output logic          mem_wren,
    output logic          busy,
`ifdef VGA_RECT_WRITER_CLEAR_EN
    input  logic          clear,
`endif
    output logic          done
);

    localparam int XMAX = LORES ? 160 : 320;
    localparam int YMAX = LORES ? 120 : 240;
    localparam logic [XW:0] XMAX_W = (XW+1)'(XMAX);
    localparam logic [YW:0] YMAX_W = (YW+1)'(YMAX);
`ifdef VGA_RECT_WRITER_CLEAR_EN
    localparam logic [AW-1:0] LAST_ADDR = AW'(XMAX * YMAX - 1);
`endif

`ifdef VGA_RECT_WRITER_CLEAR_EN
    typedef enum logic [1:0] {IDLE, FILL, FINISH, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL, FINISH} state_t;
`endif

    state_t        state;
    logic          ready_q;
    logic [XW-1:0] x0, ew, cx;
    logic [YW-1:0] y0, eh, cy;

    // Row base by shift-add: 320 = 256 + 64, 160 = 128 + 32. Sums are kept one
    // bit wider than the address; clipping keeps the result below XMAX*YMAX.
    function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [AW:0] ye;
        logic [AW:0] xe;
        logic [AW:0] sum;
        ye = {{(AW+1-YW){1'b0}}, y};
        xe = {{(AW+1-XW){1'b0}}, x};
        if (LORES)
            sum = (ye << 7) + (ye << 5) + xe;
        else
            sum = (ye << 8) + (ye << 6) + xe;
        return sum[AW-1:0];
    endfunction

    // Clipping of the offered command, evaluated at capture.
    logic [XW:0]   x_room;
    logic [YW:0]   y_room;
    logic [XW-1:0] cap_ew;
    logic [YW-1:0] cap_eh;
    logic          cap_empty;

    always_comb begin
        x_room    = XMAX_W - {1'b0, cmd_x};
        y_room    = YMAX_W - {1'b0, cmd_y};
        cap_ew    = ({1'b0, cmd_w} < x_room) ? cmd_w : x_room[XW-1:0];
        cap_eh    = ({1'b0, cmd_h} < y_room) ? cmd_h : y_room[YW-1:0];
        cap_empty = ({1'b0, cmd_x} >= XMAX_W) || ({1'b0, cmd_y} >= YMAX_W) ||
                    (cap_ew == '0) || (cap_eh == '0);
    end

    // Coordinates of the dot following the one currently on the write port.
    logic          last_col, last_row;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;

    always_comb begin
        last_col = (cx == ew - 1'b1);
        last_row = (cy == eh - 1'b1);
        nx       = last_col ? x0 : x0 + cx + 1'b1;
        ny       = last_col ? y0 + cy + 1'b1 : y0 + cy;
    end

    // A pending clear takes priority over a command, so the handshake is masked.
`ifdef VGA_RECT_WRITER_CLEAR_EN
    assign cmd_ready = ready_q & ~clear;
`else
    assign cmd_ready = ready_q;
`endif

    logic cmd_accept;
    assign cmd_accept = cmd_valid & cmd_ready;

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_wren    <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            x0          <= '0;
            y0          <= '0;
            ew          <= '0;
            eh          <= '0;
            cx          <= '0;
            cy          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
`ifdef VGA_RECT_WRITER_CLEAR_EN
                    if (clear) begin
                        state       <= CLEAR;
                        ready_q     <= 1'b0;
                        busy        <= 1'b1;
                        mem_address <= '0;
                        mem_data    <= '0;
                        mem_wren    <= 1'b1;
                    end else
`endif
                    if (cmd_accept) begin
                        x0      <= cmd_x;
                        y0      <= cmd_y;
                        ew      <= cap_ew;
                        eh      <= cap_eh;
                        cx      <= '0;
                        cy      <= '0;
                        ready_q <= 1'b0;
                        busy    <= 1'b1;
                        if (cap_empty) begin
                            // Nothing visible: report completion without writing.
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state       <= FILL;
                            mem_address <= pix_addr(cmd_x, cmd_y);
                            mem_data    <= cmd_colour;
                            mem_wren    <= 1'b1;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (last_col && last_row) begin
                        state    <= FINISH;
                        mem_wren <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        cx          <= last_col ? '0 : cx + 1'b1;
                        cy          <= last_col ? cy + 1'b1 : cy;
                        mem_address <= pix_addr(nx, ny);
                    end
                end
                FINISH: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    ready_q <= 1'b1;
                end
`ifdef VGA_RECT_WRITER_CLEAR_EN
                CLEAR: begin
                    if (mem_address == LAST_ADDR) begin
                        state    <= FINISH;
                        mem_wren <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        mem_address <= mem_address + 1'b1;
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mem_wren <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_writer.sv
// tb/tb_vga_rect_writer.sv - self-checking bench for vga_rect_writer
module tb_vga_rect_writer;

`ifdef VGA_RECT_WRITER_CLEAR_EN
    localparam string RES = "160x120";
    localparam int XMAX = 160, YMAX = 120, XW = 8, YW = 7, AW = 15;
`else
    localparam string RES = "320x240";
    localparam int XMAX = 320, YMAX = 240, XW = 9, YW = 8, AW = 17;
`endif
    localparam int CW = 3;

    logic          vga_clock = 1'b0;
    logic          resetn    = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [XW-1:0] cmd_x = '0;
    logic [YW-1:0] cmd_y = '0;
    logic [XW-1:0] cmd_w = '0;
    logic [YW-1:0] cmd_h = '0;
    logic [CW-1:0] cmd_colour = '0;
    logic [AW-1:0] mem_address;
    logic [CW-1:0] mem_data;
    logic          mem_wren;
    logic          busy;
    logic          done;
`ifdef VGA_RECT_WRITER_CLEAR_EN
    logic          clear = 1'b0;
`endif

    vga_rect_writer #(.RESOLUTION(RES)) dut (
        .vga_clock  (vga_clock),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .busy       (busy),
`ifdef VGA_RECT_WRITER_CLEAR_EN
        .clear      (clear),
`endif
        .done       (done)
    );

    always #5 vga_clock = ~vga_clock;

    int cyc = 0;
    always @(posedge vga_clock) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    int last_done   = -100;
    int exp_addr[$];

    int nxt_x = 0, nxt_y = 0, nxt_w = 0, nxt_h = 0, nxt_c = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: every dot of the unclipped rectangle, kept only if on screen,
    // in raster order.
    task automatic model(input int x, input int y, input int w, input int h);
        exp_addr.delete();
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                if (x + c < XMAX && y + r < YMAX)
                    exp_addr.push_back((y + r) * XMAX + (x + c));
    endtask

    // Entered just after a negedge with the engine idle; returns just after the
    // negedge following done, having checked the return to idle.
    task automatic do_cmd(input int x, input int y, input int w, input int h, input int col,
                          input bit hold, input bit tight);
        int wr_cyc[$];
        int wr_addr[$];
        int wr_data[$];
        int acc, done_cyc, budget, n;
        bit busy_ok;
        cmd_x = XW'(x); cmd_y = YW'(y); cmd_w = XW'(w); cmd_h = YW'(h); cmd_colour = CW'(col);
        cmd_valid = 1'b1;
        model(int'(cmd_x), int'(cmd_y), int'(cmd_w), int'(cmd_h));
        n = exp_addr.size();
        #1;
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 100) begin
            @(negedge vga_clock); #1; budget++;
        end
        check("accept_wait", budget < 100, 1'b1);
        acc = cyc + 1;
        if (tight) check("b2b_gap", acc, last_done + 2);
        @(negedge vga_clock);
        if (hold) begin
            cmd_x = XW'(nxt_x); cmd_y = YW'(nxt_y); cmd_w = XW'(nxt_w);
            cmd_h = YW'(nxt_h); cmd_colour = CW'(nxt_c);
        end else begin
            cmd_valid = 1'b0;
        end
        done_cyc = -1; budget = 0; busy_ok = 1'b1;
        while (budget < 30000) begin
            if (mem_wren === 1'b1) begin
                wr_cyc.push_back(cyc); wr_addr.push_back(int'(mem_address)); wr_data.push_back(int'(mem_data));
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin done_cyc = cyc; break; end
            @(negedge vga_clock); budget++;
        end
        check("done_cycle", done_cyc, acc + n);
        check("write_count", wr_addr.size(), n);
        check("busy_during", busy_ok, 1'b1);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check("write_addr", wr_addr[i], exp_addr[i]);
            check("write_data", wr_data[i], col & 7);
            check("write_cycle", wr_cyc[i], acc + i);
        end
        last_done = done_cyc;
        @(negedge vga_clock);
        #1;
        check("ready_after", cmd_ready, 1'b1);
        check("busy_after", busy, 1'b0);
        check("wren_after", mem_wren, 1'b0);
    endtask

    initial begin
        int acc, cnt;
        resetn = 1'b0;
        repeat (3) @(negedge vga_clock);
        #1;
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_wren", mem_wren, 1'b0);
        check("rst_addr", mem_address, 0);
        check("rst_data", mem_data, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge vga_clock);
        resetn = 1'b1;
        @(negedge vga_clock);
        #1;
        check("ready_post_rst", cmd_ready, 1'b1);

        do_cmd(0, 0, 1, 1, 5, 1'b0, 1'b0);
        do_cmd(10, 5, 3, 2, 2, 1'b0, 1'b0);
        do_cmd(318, 239, 4, 2, 7, 1'b0, 1'b0);
        do_cmd(320, 0, 5, 5, 3, 1'b0, 1'b0);
        do_cmd(7, 7, 0, 3, 1, 1'b0, 1'b0);

        // Back-to-back: second command offered (held valid) throughout the first.
        nxt_x = 50; nxt_y = 60; nxt_w = 2; nxt_h = 3; nxt_c = 6;
        do_cmd(100, 100, 3, 3, 1, 1'b1, 1'b0);
        do_cmd(50, 60, 2, 3, 6, 1'b0, 1'b1);

        // Reset during the third write of a 4x4 fill.
        cmd_x = 20; cmd_y = 10; cmd_w = 4; cmd_h = 4; cmd_colour = 3'd4; cmd_valid = 1'b1;
        model(20, 10, 4, 4);
        #1;
        cnt = 0;
        while (cmd_ready !== 1'b1 && cnt < 100) begin @(negedge vga_clock); #1; cnt++; end
        acc = cyc + 1;
        @(negedge vga_clock);
        cmd_valid = 1'b0;
        @(negedge vga_clock);
        @(negedge vga_clock);
        check("rstmid_cycle", cyc, acc + 2);
        check("rstmid_third_addr", mem_address, exp_addr[2]);
        check("rstmid_third_wren", mem_wren, 1'b1);
        resetn = 1'b0;
        #1;
        check("rstmid_wren", mem_wren, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_ready", cmd_ready, 1'b0);
        check("rstmid_addr", mem_address, 0);
        check("rstmid_done", done, 1'b0);
        @(negedge vga_clock);
        @(negedge vga_clock);
        resetn = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge vga_clock);
            if (mem_wren === 1'b1) cnt++;
        end
        #1;
        check("rstmid_no_writes", cnt, 0);
        check("rstmid_ready_after", cmd_ready, 1'b1);
        check("rstmid_busy_after", busy, 1'b0);

        // Randomized rectangles, many partly or fully off screen.
        for (int k = 0; k < 30; k++) begin
            do_cmd($urandom_range(XMAX + 10, 0), $urandom_range(YMAX + 10, 0),
                   $urandom_range(8, 0), $urandom_range(6, 0), $urandom_range(7, 0),
                   1'b0, 1'b0);
        end

`ifdef VGA_RECT_WRITER_CLEAR_EN
        begin
            int ccount, cbad, cdata_bad, cdone, cready_bad, cb;
            cmd_x = 5; cmd_y = 6; cmd_w = 2; cmd_h = 2; cmd_colour = 3'd3;
            cmd_valid = 1'b1;
            clear = 1'b1;
            #1;
            check("clear_masks_ready", cmd_ready, 1'b0);
            acc = cyc + 1;
            @(negedge vga_clock);
            clear = 1'b0;
            ccount = 0; cbad = 0; cdata_bad = 0; cdone = -1; cready_bad = 0; cb = 0;
            while (cb < 25000) begin
                if (mem_wren === 1'b1) begin
                    if (int'(mem_address) != ccount) cbad++;
                    if (mem_data !== '0) cdata_bad++;
                    ccount++;
                end
                if (cmd_ready !== 1'b0) cready_bad++;
                if (done === 1'b1) begin cdone = cyc; break; end
                @(negedge vga_clock); cb++;
            end
            check("clear_count", ccount, XMAX * YMAX);
            check("clear_addr_seq", cbad, 0);
            check("clear_data", cdata_bad, 0);
            check("clear_done_cycle", cdone, acc + XMAX * YMAX);
            check("clear_no_accept", cready_bad, 0);
            last_done = cdone;
            @(negedge vga_clock);
            do_cmd(5, 6, 2, 2, 3, 1'b0, 1'b1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
